// File: rtl/tower_grid_cursor.sv
// tower_grid_cursor: cursor and tower placement engine for a cell grid.
// Each accepted command redraws the affected cell(s) as a pixel stream
// with a valid/ready handshake.
// Optional build macro TOWER_GRID_SELL_EN compiles in the sell command;
// without it cmd_sell is ignored and towers are only cleared by reset.
module tower_grid_cursor #(
  parameter int         GRID_COLS     = 8,
  parameter int         GRID_ROWS     = 6,
  parameter int         CELL_SIZE     = 20,
  parameter logic [8:0] CURSOR_COLOUR = 9'h1C0,
  parameter logic [8:0] TOWER_COLOUR  = 9'h03F,
  parameter logic [8:0] BG_COLOUR     = 9'h000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_left,
  input  logic       cmd_right,
  input  logic       cmd_up,
  input  logic       cmd_down,
  input  logic       cmd_place,
  input  logic       cmd_sell,
  input  logic       pix_ready,
  output logic       pix_valid,
  output logic [7:0] pix_x,
  output logic [6:0] pix_y,
  output logic [8:0] pix_colour,
  output logic       busy,
  output logic [3:0] cur_col,
  output logic [2:0] cur_row,
  output logic       place_ok,
  output logic       place_err
);

  localparam int NCELL = GRID_COLS * GRID_ROWS;
  localparam int IW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int CW    = (CELL_SIZE > 1) ? $clog2(CELL_SIZE) : 1;
  localparam logic [CW-1:0] PLAST    = CW'(CELL_SIZE - 1);
  localparam logic [3:0]    COL_LAST = 4'(GRID_COLS - 1);
  localparam logic [2:0]    ROW_LAST = 3'(GRID_ROWS - 1);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW_TOWER, DRAW_CURSOR} state_t;

  state_t          state, state_nxt;
  logic [NCELL-1:0] occ;
  logic [CW-1:0]   px, py;
  logic [3:0]      tgt_col, tgt_col_d;
  logic [2:0]      tgt_row, tgt_row_d;
  logic [IW-1:0]   cell_idx;
  logic            cell_occ;
  logic            acc_place, acc_move;
  logic            hs, last_pix;
`ifdef TOWER_GRID_SELL_EN
  logic            acc_sell;
`else
  logic            unused_sell;
  assign unused_sell = cmd_sell;
`endif

  assign cell_idx = IW'(32'(cur_row) * GRID_COLS + 32'(cur_col));
  assign cell_occ = occ[cell_idx];
  assign hs       = pix_valid & pix_ready;
  assign last_pix = (px == PLAST) && (py == PLAST);

  // Command decode with fixed priority; target cell wraps at grid edges
  always_comb begin
    acc_place = 1'b0;
    acc_move  = 1'b0;
    tgt_col_d = cur_col;
    tgt_row_d = cur_row;
`ifdef TOWER_GRID_SELL_EN
    acc_sell  = 1'b0;
`endif
    if (cmd_place) acc_place = 1'b1;
`ifdef TOWER_GRID_SELL_EN
    else if (cmd_sell) acc_sell = 1'b1;
`endif
    else if (cmd_right) begin
      acc_move  = 1'b1;
      tgt_col_d = (cur_col == COL_LAST) ? 4'd0 : cur_col + 4'd1;
    end else if (cmd_left) begin
      acc_move  = 1'b1;
      tgt_col_d = (cur_col == 4'd0) ? COL_LAST : cur_col - 4'd1;
    end else if (cmd_down) begin
      acc_move  = 1'b1;
      tgt_row_d = (cur_row == ROW_LAST) ? 3'd0 : cur_row + 3'd1;
    end else if (cmd_up) begin
      acc_move  = 1'b1;
      tgt_row_d = (cur_row == 3'd0) ? ROW_LAST : cur_row - 3'd1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: drawing states end on the handshake of their last pixel
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (acc_place) begin
          if (!cell_occ) state_nxt = DRAW_TOWER;
        end
`ifdef TOWER_GRID_SELL_EN
        else if (acc_sell) begin
          if (cell_occ) state_nxt = ERASE;
        end
`endif
        else if (acc_move) state_nxt = ERASE;
      end
      ERASE, DRAW_TOWER: if (hs && last_pix) state_nxt = DRAW_CURSOR;
      DRAW_CURSOR:       if (hs && last_pix) state_nxt = IDLE;
      default:           state_nxt = IDLE;
    endcase
  end

  // Cursor, occupancy, result pulses and in-cell pixel counters
  always_ff @(posedge clk) begin
    if (reset) begin
      occ       <= '0;
      cur_col   <= 4'd0;
      cur_row   <= 3'd0;
      tgt_col   <= 4'd0;
      tgt_row   <= 3'd0;
      px        <= '0;
      py        <= '0;
      place_ok  <= 1'b0;
      place_err <= 1'b0;
    end else begin
      place_ok  <= 1'b0;
      place_err <= 1'b0;
      if (state == IDLE) begin
        px      <= '0;
        py      <= '0;
        tgt_col <= tgt_col_d;
        tgt_row <= tgt_row_d;
        if (acc_place) begin
          if (cell_occ) place_err <= 1'b1;
          else begin
            occ[cell_idx] <= 1'b1;
            place_ok      <= 1'b1;
          end
        end
`ifdef TOWER_GRID_SELL_EN
        else if (acc_sell) begin
          if (cell_occ) begin
            occ[cell_idx] <= 1'b0;
            place_ok      <= 1'b1;
          end else place_err <= 1'b1;
        end
`endif
      end else if (hs) begin
        if (last_pix) begin
          px <= '0;
          py <= '0;
          // The cursor moves only once the old cell has been erased
          if (state == ERASE) begin
            cur_col <= tgt_col;
            cur_row <= tgt_row;
          end
        end else if (px == PLAST) begin
          px <= '0;
          py <= py + 1'b1;
        end else if (state == DRAW_CURSOR && py != '0 && py != PLAST) begin
          // Interior rows of the border: jump from left edge to right edge
          px <= PLAST;
        end else begin
          px <= px + 1'b1;
        end
      end
    end
  end

  // Pixel stream outputs; everything reads zero while idle
  always_comb begin
    busy       = (state != IDLE);
    pix_valid  = busy;
    pix_x      = 8'd0;
    pix_y      = 7'd0;
    pix_colour = 9'd0;
    if (busy) begin
      pix_x = 8'(32'(cur_col) * CELL_SIZE + 32'(px));
      pix_y = 7'(32'(cur_row) * CELL_SIZE + 32'(py));
      case (state)
        ERASE:       pix_colour = cell_occ ? TOWER_COLOUR : BG_COLOUR;
        DRAW_TOWER:  pix_colour = TOWER_COLOUR;
        DRAW_CURSOR: pix_colour = CURSOR_COLOUR;
        default:     pix_colour = BG_COLOUR;
      endcase
    end
  end

endmodule

// File: tb/tb_tower_grid_cursor.sv
// Bench for tower_grid_cursor (default build, sell disabled).
module tb_tower_grid_cursor;

  localparam int CS = 20;
  localparam int NC = 8;
  localparam int NR = 6;
  localparam logic [8:0] CUR_C = 9'h1C0;
  localparam logic [8:0] TOW_C = 9'h03F;
  localparam logic [8:0] BG_C  = 9'h000;
  localparam logic [5:0] C_PLACE = 6'b100000;
  localparam logic [5:0] C_SELL  = 6'b010000;
  localparam logic [5:0] C_RIGHT = 6'b001000;
  localparam logic [5:0] C_LEFT  = 6'b000100;
  localparam logic [5:0] C_UP    = 6'b000001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_left = 1'b0, cmd_right = 1'b0, cmd_up = 1'b0, cmd_down = 1'b0;
  logic cmd_place = 1'b0, cmd_sell = 1'b0;
  logic pix_ready = 1'b1;
  logic       pix_valid, busy, place_ok, place_err;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [8:0] pix_colour;
  logic [3:0] cur_col;
  logic [2:0] cur_row;

  int n_chk = 0;
  int n_fail = 0;
  int q[$];
  int acc_cnt = 0;
  int base = 0;
  bit tgl = 1'b0;
  bit occ[NC*NR];
  int m_col = 0, m_row = 0;
  bit prev_stall = 1'b0;
  int prev_pix = 0;

  always #5 clk = ~clk;

  tower_grid_cursor dut (
    .clk(clk), .reset(reset),
    .cmd_left(cmd_left), .cmd_right(cmd_right), .cmd_up(cmd_up),
    .cmd_down(cmd_down), .cmd_place(cmd_place), .cmd_sell(cmd_sell),
    .pix_ready(pix_ready), .pix_valid(pix_valid), .pix_x(pix_x),
    .pix_y(pix_y), .pix_colour(pix_colour), .busy(busy),
    .cur_col(cur_col), .cur_row(cur_row),
    .place_ok(place_ok), .place_err(place_err)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int pk(input int col, input int row, input int px, input int py,
                            input logic [8:0] c);
    logic [7:0] x;
    logic [6:0] y;
    x = 8'(col * CS + px);
    y = 7'(row * CS + py);
    return 32'({x, y, c});
  endfunction

  task automatic push_fill(input int col, input int row, input logic [8:0] c);
    for (int py = 0; py < CS; py++)
      for (int px = 0; px < CS; px++) q.push_back(pk(col, row, px, py, c));
  endtask

  task automatic push_border(input int col, input int row);
    for (int py = 0; py < CS; py++)
      for (int px = 0; px < CS; px++)
        if (py == 0 || py == CS-1 || px == 0 || px == CS-1)
          q.push_back(pk(col, row, px, py, CUR_C));
  endtask

  // Ready source: constant 1, or toggling every cycle when tgl is set
  always @(posedge clk) begin
    #1;
    if (tgl) pix_ready = ~pix_ready;
    else     pix_ready = 1'b1;
  end

  // Scoreboard consumer: pops on every accepted pixel, checks hold on stalls
  always @(negedge clk) begin
    int cur;
    cur = 32'({pix_x, pix_y, pix_colour});
    if (!busy) chk("idle_valid", 32'(pix_valid), 0);
    if (pix_valid) begin
      if (prev_stall) chk("hold", cur, prev_pix);
      if (pix_ready) begin
        acc_cnt++;
        if (q.size() == 0) chk("pix_extra", 1, 0);
        else               chk("pix", cur, q.pop_front());
      end
    end
    prev_stall = pix_valid && !pix_ready;
    prev_pix   = cur;
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ":timeout"}, 32'(busy), 0);
  endtask

  // Model the command, queue expected pixels, then strobe it for one cycle
  task automatic start_cmd(input logic [5:0] c, output int draw, output int ok,
                           output int err, output int nc, output int nr);
    int idx;
    draw = 0; ok = 0; err = 0; nc = m_col; nr = m_row;
    idx = m_row * NC + m_col;
    if (c[5]) begin
      if (occ[idx]) err = 1;
      else begin
        occ[idx] = 1'b1;
        ok = 1; draw = 1;
        push_fill(m_col, m_row, TOW_C);
        push_border(m_col, m_row);
      end
    end else if (c[3:0] != 4'd0) begin
      if (c[3])      nc = (m_col + 1) % NC;
      else if (c[2]) nc = (m_col + NC - 1) % NC;
      else if (c[1]) nr = (m_row + 1) % NR;
      else           nr = (m_row + NR - 1) % NR;
      draw = 1;
      push_fill(m_col, m_row, occ[idx] ? TOW_C : BG_C);
      push_border(nc, nr);
    end
    base = acc_cnt;
    {cmd_place, cmd_sell, cmd_right, cmd_left, cmd_down, cmd_up} = c;
    @(posedge clk); #1;
    {cmd_place, cmd_sell, cmd_right, cmd_left, cmd_down, cmd_up} = 6'd0;
  endtask

  task automatic finish_cmd(input string tag, input int draw, input int nc, input int nr);
    if (draw != 0) begin
      wait_idle(tag);
      chk({tag, ":count"}, acc_cnt - base, 476);
    end else begin
      @(posedge clk); #1;
      chk({tag, ":busy"}, 32'(busy), 0);
      chk({tag, ":pulse1"}, 32'(place_ok | place_err), 0);
    end
    m_col = nc; m_row = nr;
    chk({tag, ":col"}, 32'(cur_col), m_col);
    chk({tag, ":row"}, 32'(cur_row), m_row);
    chk({tag, ":queue"}, q.size(), 0);
  endtask

  task automatic do_cmd(input string tag, input logic [5:0] c);
    int draw, ok, err, nc, nr;
    start_cmd(c, draw, ok, err, nc, nr);
    chk({tag, ":ok"}, 32'(place_ok), ok);
    chk({tag, ":err"}, 32'(place_err), err);
    chk({tag, ":lat"}, 32'(pix_valid), draw);
    finish_cmd(tag, draw, nc, nr);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int draw, ok, err, nc, nr, n;
    for (int i = 0; i < NC*NR; i++) occ[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst:valid",  32'(pix_valid), 0);
    chk("rst:x",      32'(pix_x), 0);
    chk("rst:y",      32'(pix_y), 0);
    chk("rst:colour", 32'(pix_colour), 0);
    chk("rst:busy",   32'(busy), 0);
    chk("rst:col",    32'(cur_col), 0);
    chk("rst:row",    32'(cur_row), 0);
    chk("rst:ok",     32'(place_ok), 0);
    chk("rst:err",    32'(place_err), 0);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("no_init_cursor", 32'(busy), 0);

    do_cmd("right", C_RIGHT);
    do_cmd("place", C_PLACE);
    do_cmd("place_again", C_PLACE);
    tgl = 1'b1;
    do_cmd("left_tgl", C_LEFT);
    tgl = 1'b0;
    do_cmd("up_wrap", C_UP);
    do_cmd("left_wrap", C_LEFT);
    do_cmd("right_wrap", C_RIGHT);

    // Place beats right in the same cycle; a down strobe mid-draw is dropped
    start_cmd(C_PLACE | C_RIGHT, draw, ok, err, nc, nr);
    chk("prio:ok", 32'(place_ok), 1);
    chk("prio:lat", 32'(pix_valid), 1);
    repeat (10) @(posedge clk);
    #1;
    cmd_down = 1'b1;
    @(posedge clk); #1;
    cmd_down = 1'b0;
    finish_cmd("prio", draw, nc, nr);

    do_cmd("sell_ignored", C_SELL);
    do_cmd("place_kept", C_PLACE);

    // Reset in the middle of a tower draw
    do_cmd("right_r", C_RIGHT);
    start_cmd(C_PLACE, draw, ok, err, nc, nr);
    n = 0;
    while ((acc_cnt - base) < 100 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort:reached", 32'((acc_cnt - base) >= 100), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort:valid", 32'(pix_valid), 0);
    chk("abort:busy",  32'(busy), 0);
    chk("abort:col",   32'(cur_col), 0);
    chk("abort:row",   32'(cur_row), 0);
    chk("abort:ok",    32'(place_ok), 0);
    reset = 1'b0;
    q.delete();
    for (int i = 0; i < NC*NR; i++) occ[i] = 1'b0;
    m_col = 0; m_row = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort:quiet", 32'(pix_valid), 0);

    // Previously occupied cells must now erase to background and accept a place
    do_cmd("post_up", C_UP);
    do_cmd("post_right", C_RIGHT);
    do_cmd("post_place", C_PLACE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tower_grid_cursor.md
TOWER_GRID_CURSOR -- requirements
Module: tower_grid_cursor

Interface
REQ-001 SHALL have parameter GRID_COLS, default 8: number of grid columns.
REQ-002 SHALL have parameter GRID_ROWS, default 6: number of grid rows.
REQ-003 SHALL have parameter CELL_SIZE, default 20: cell edge length in pixels.
REQ-004 SHALL have parameters CURSOR_COLOUR, default 9'h1C0, TOWER_COLOUR, default 9'h03F, and BG_COLOUR, default 9'h000: 9-bit pixel colours.
REQ-005 SHALL have port clk  input  1: the only clock; every register updates on its rising edge.
REQ-006 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-007 SHALL have ports cmd_left, cmd_right, cmd_up, cmd_down, cmd_place, cmd_sell  input  1 each: single-cycle command strobes.
REQ-008 SHALL have port pix_ready  input  1: the downstream pixel sink accepts the current pixel.
REQ-009 SHALL have ports pix_valid  output  1, pix_x  output  8, pix_y  output  7, pix_colour  output  9: the pixel stream.
REQ-010 SHALL have ports busy  output  1, cur_col  output  4, cur_row  output  3: engine busy flag and cursor cell.
REQ-011 SHALL have ports place_ok, place_err  output  1 each: one-cycle result pulses.

Function
REQ-012 SHALL use the FSM states IDLE, ERASE, DRAW_TOWER, DRAW_CURSOR; busy SHALL be 1 in every state except IDLE.
REQ-013 SHALL accept commands only in IDLE; commands arriving while busy=1 SHALL be dropped.
REQ-014 SHALL apply a fixed priority to simultaneous strobes: place > sell > right > left > down > up.
REQ-015 On a move, SHALL go IDLE->ERASE (old cell), update cur_col/cur_row, then go DRAW_CURSOR (new cell) -> IDLE.
REQ-016 SHALL wrap moves: right from GRID_COLS-1 goes to 0, left from 0 goes to GRID_COLS-1; down and up wrap the same way over GRID_ROWS.
REQ-017 ERASE SHALL emit every pixel of the cell: BG_COLOUR where the occupancy bit is 0, TOWER_COLOUR where it is 1.
REQ-018 DRAW_CURSOR SHALL emit only the cell's 1-pixel border (4*CELL_SIZE-4 pixels) in CURSOR_COLOUR.
REQ-019 DRAW_TOWER SHALL emit every cell pixel in TOWER_COLOUR, then go to DRAW_CURSOR.
REQ-020 Pixel order SHALL be raster, x-inner; pix_x = cur_col*CELL_SIZE + px and pix_y = cur_row*CELL_SIZE + py, truncated to 8 and 7 bits.
REQ-021 The pixel handshake SHALL advance only on the cycle where pix_valid=1 and pix_ready=1; pix_x, pix_y and pix_colour SHALL hold stable while pix_valid=1 and pix_ready=0.
REQ-022 pix_valid SHALL be 0 in IDLE; the FSM SHALL leave a drawing state on the cycle that the last pixel is accepted.
REQ-023 SHALL keep a GRID_COLS*GRID_ROWS occupancy bit array, one bit per cell.
REQ-024 cmd_place on an empty cell: set the bit, pulse place_ok the next cycle, go DRAW_TOWER.
REQ-025 cmd_place on an occupied cell: pulse place_err the next cycle, stay in IDLE, emit no pixels.
REQ-026 Latency: first pixel_valid SHALL occur 1 cycle after the accepted command.

Reset
REQ-027 reset SHALL force: state IDLE, cur_col=0, cur_row=0, all occupancy bits 0, pix_valid=0, pix_x=0, pix_y=0, pix_colour=0, busy=0, place_ok=0, place_err=0.
REQ-028 reset asserted mid-draw SHALL abort the draw the next cycle; no further pixels are emitted and no completion pulse occurs.
REQ-029 After reset is released, the block SHALL NOT draw the initial cursor until a command is accepted.

Configuration
REQ-030 SHALL compile in sell support when macro TOWER_GRID_SELL_EN is defined.
REQ-031 With TOWER_GRID_SELL_EN defined, cmd_sell on an occupied cell: clear the bit, pulse place_ok, then run ERASE (all BG_COLOUR) followed by DRAW_CURSOR.
REQ-032 With TOWER_GRID_SELL_EN defined, cmd_sell on an empty cell: pulse place_err and emit no pixels.
REQ-033 Without TOWER_GRID_SELL_EN, cmd_sell SHALL be ignored in every state and no occupancy bit SHALL ever be cleared except by reset.

Verification
REQ-034 Reset, then cmd_right with pix_ready=1: 400 ERASE pixels at x 0..19, y 0..19 in BG_COLOUR, then 76 border pixels at x 20..39 in CURSOR_COLOUR; cur_col=1; busy falls after 476 accepted pixels.
REQ-035 With cursor at col 7, cmd_right: cur_col=0 (wrap); with cursor at row 0, cmd_up: cur_row=5.
REQ-036 cmd_place at (0,0): place_ok pulse, 400 TOWER_COLOUR pixels then 76 cursor pixels; a second cmd_place at (0,0): place_err pulse, pix_valid stays 0.
REQ-037 Toggle pix_ready 1/0 every cycle during a draw: pixel count and sequence match the pix_ready=1 case; outputs hold stable while pix_ready=0.
REQ-038 cmd_right and cmd_place in the same cycle: place wins; cmd_down while busy=1: dropped and cur_row unchanged.
REQ-039 Assert reset at pixel 100 of DRAW_TOWER: pix_valid=0 the next cycle, occupancy all 0, cursor (0,0); with TOWER_GRID_SELL_EN defined, place then sell at (2,3) leaves the bit clear.
